// File: rtl/aha_clock_switch_ctrl.sv
// Break-before-make sequencer for a bank of glitch-free clock switch slices.
// Runs on an always-on control clock; slice acknowledges are synchronised
// before any decision is made on them. Boots to RESET_SEL out of reset and
// reboots to RESET_SEL when a timeout fault is cleared.
module aha_clock_switch_ctrl #(
  parameter int NUM_CLKS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int RESET_SEL      = 0,
  localparam int SEL_W         = $clog2(NUM_CLKS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                switch_req_i,
  input  logic [SEL_W-1:0]    switch_sel_i,
  output logic                switch_ready_o,
  output logic                switch_done_o,
  output logic [NUM_CLKS-1:0] select_req_o,
  input  logic [NUM_CLKS-1:0] select_ack_i,
  output logic [SEL_W-1:0]    cur_sel_o,
  output logic                busy_o,
  output logic                err_invalid_o,
  output logic                err_timeout_o,
  input  logic                err_clr_i
);

  localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DROP  = 2'd1,
    RAISE = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e                          state_q;
  logic [SEL_W-1:0]                target_q;
  logic [SEL_W-1:0]                cur_sel_q;
  logic [NUM_CLKS-1:0]             select_req_q;
  logic [TMR_W-1:0]                timer_q;
  logic                            ready_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_invalid_q;
  logic                            err_timeout_q;
  logic [SYNC_STAGES-1:0][NUM_CLKS-1:0] sync_q;

  logic [NUM_CLKS-1:0] ack_s;
  logic                sel_invalid;
  logic                accept;
  logic                timed_out;

  // Single-bit request vector for a source index.
  function automatic logic [NUM_CLKS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = {{(NUM_CLKS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign sel_invalid = ({1'b0, switch_sel_i} >= (SEL_W+1)'(NUM_CLKS));
  assign accept      = switch_req_i & ready_q;
  assign timed_out   = (timer_q == TMR_W'(TIMEOUT_CYCLES));

  // Acks come from other clock domains, so each bit passes through a flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      for (int s = SYNC_STAGES - 1; s > 0; s--) begin
        sync_q[s] <= sync_q[s-1];
      end
      sync_q[0] <= select_ack_i;
    end
  end

  // Sequencer: drop every request, wait for all acks low, raise the target, wait for its ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= DROP;
      target_q      <= SEL_W'(RESET_SEL);
      cur_sel_q     <= SEL_W'(RESET_SEL);
      select_req_q  <= '0;
      timer_q       <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (err_clr_i) begin
        err_invalid_q <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (sel_invalid) begin
              err_invalid_q <= 1'b1;
              done_q        <= 1'b1;
            end else if (switch_sel_i == cur_sel_q) begin
              done_q <= 1'b1;
            end else begin
              target_q     <= switch_sel_i;
              select_req_q <= '0;
              timer_q      <= '0;
              ready_q      <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= DROP;
            end
          end
        end
        DROP: begin
          if (ack_s == '0) begin
            select_req_q <= onehot(target_q);
            timer_q      <= '0;
            state_q      <= RAISE;
          end else if (timed_out) begin
            select_req_q  <= '0;
            err_timeout_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= FAULT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        RAISE: begin
          if (ack_s == onehot(target_q)) begin
            cur_sel_q <= target_q;
            done_q    <= 1'b1;
            timer_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (timed_out) begin
            select_req_q  <= '0;
            err_timeout_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= FAULT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        FAULT: begin
          select_req_q <= '0;
          if (err_clr_i) begin
            target_q <= SEL_W'(RESET_SEL);
            timer_q  <= '0;
            state_q  <= DROP;
          end
        end
        default: begin
          select_req_q <= '0;
          timer_q      <= '0;
          state_q      <= FAULT;
        end
      endcase
    end
  end

  assign switch_ready_o = ready_q;
  assign switch_done_o  = done_q;
  assign select_req_o   = select_req_q;
  assign cur_sel_o      = cur_sel_q;
  assign busy_o         = busy_q;
  assign err_invalid_o  = err_invalid_q;
  assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_aha_clock_switch_ctrl.sv
// Bench for aha_clock_switch_ctrl: randomly delayed slice models, transaction-level
// expectations for each switch request, and per-cycle invariant checks.
module tb_aha_clock_switch_ctrl;

  localparam int NUM_CLKS       = 3;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int RESET_SEL      = 0;
  localparam int SEL_W          = 2;

  logic                clk = 1'b0;
  logic                rstN = 1'b1;
  logic                switchReq = 1'b0;
  logic [SEL_W-1:0]    switchSel = '0;
  logic                errClr = 1'b0;
  logic                switchReady;
  logic                switchDone;
  logic [NUM_CLKS-1:0] selectReq;
  logic [NUM_CLKS-1:0] selectAck;
  logic [SEL_W-1:0]    curSel;
  logic                busy;
  logic                errInvalid;
  logic                errTimeout;

  logic [NUM_CLKS-1:0] sliceAck = '0;
  logic [NUM_CLKS-1:0] stuckHigh = '0;
  int                  sliceWait [NUM_CLKS] = '{default: 0};

  int compCount = 0;
  int failCount = 0;
  int curModel = RESET_SEL;
  int errInvModel = 0;

  aha_clock_switch_ctrl #(
    .NUM_CLKS      (NUM_CLKS),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RESET_SEL     (RESET_SEL)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .switch_req_i  (switchReq),
    .switch_sel_i  (switchSel),
    .switch_ready_o(switchReady),
    .switch_done_o (switchDone),
    .select_req_o  (selectReq),
    .select_ack_i  (selectAck),
    .cur_sel_o     (curSel),
    .busy_o        (busy),
    .err_invalid_o (errInvalid),
    .err_timeout_o (errTimeout),
    .err_clr_i     (errClr)
  );

  always #5 clk = ~clk;

  assign selectAck = sliceAck | stuckHigh;

  // Each slice follows its request after a random 1-3 cycle delay; stuckHigh models a broken slice.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (sliceAck[i] !== selectReq[i]) begin
        if (sliceWait[i] <= 0) begin
          sliceAck[i]  <= selectReq[i];
          sliceWait[i] <= $urandom_range(0, 2);
        end else begin
          sliceWait[i] <= sliceWait[i] - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NUM_CLKS-1:0] sourceBit(input int idx);
    logic [NUM_CLKS-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string tag);
    int cycles;
    cycles = 0;
    while (switchReady !== 1'b1 && cycles < 80) begin
      stepClk();
      cycles++;
    end
    checkOutput(tag, switchReady, 1'b1);
  endtask

  // One request from IDLE; the expected outcome comes from the current-source/sticky-error model.
  task automatic applyStimulus(input int sel, input logic clr);
    bit expectSwitch;
    int cycles;
    switchReq = 1'b1;
    switchSel = SEL_W'(sel);
    errClr    = clr;
    if (clr) errInvModel = 0;
    if (sel >= NUM_CLKS) begin
      errInvModel  = 1;
      expectSwitch = 0;
    end else begin
      expectSwitch = (sel != curModel);
    end
    stepClk();
    errClr = 1'b0;
    checkOutput("errInvalidAfterAccept", errInvalid, errInvModel);
    if (!expectSwitch) begin
      switchReq = 1'b0;
      checkOutput("noopDoneNext", switchDone, 1'b1);
      checkOutput("noopReqUnchanged", selectReq, sourceBit(curModel));
      checkOutput("noopStillReady", switchReady, 1'b1);
      stepClk();
      checkOutput("noopDoneSingle", switchDone, 1'b0);
      checkOutput("noopCurSel", curSel, curModel);
    end else begin
      // requests while busy must be ignored, so keep throwing noise at the port
      switchReq = 1'($urandom_range(0, 1));
      switchSel = SEL_W'($urandom);
      checkOutput("switchReqDropped", selectReq, '0);
      checkOutput("switchBusy", busy, 1'b1);
      checkOutput("switchNoEarlyDone", switchDone, 1'b0);
      cycles = 0;
      while (switchDone !== 1'b1 && cycles < 60) begin
        stepClk();
        cycles++;
        checkOutput("reqDuringSwitch", (selectReq == '0) || (selectReq == sourceBit(sel)), 1'b1);
        switchReq = 1'($urandom_range(0, 1));
        switchSel = SEL_W'($urandom);
      end
      switchReq = 1'b0;
      curModel  = sel;
      checkOutput("switchDone", switchDone, 1'b1);
      checkOutput("switchCurSel", curSel, curModel);
      checkOutput("switchReqFinal", selectReq, sourceBit(curModel));
      checkOutput("switchReadyAgain", switchReady, 1'b1);
      stepClk();
      checkOutput("switchDoneSingle", switchDone, 1'b0);
      checkOutput("switchErrInvalidKept", errInvalid, errInvModel);
    end
    checkOutput("errTimeoutQuiet", errTimeout, 1'b0);
  endtask

  // Every cycle: at most one request bit, BUSY mirrors READY, and a request only rises after all acks were low.
  logic [NUM_CLKS-1:0] prevReq = '0;
  bit                  ackLowSeen = 1'b1;
  always @(negedge clk) begin
    if (!rstN) begin
      ackLowSeen = 1'b1;
      prevReq    = '0;
    end else begin
      checkOutput("reqOneHotOrZero", ($countones(selectReq) <= 1), 1'b1);
      checkOutput("busyVsReady", busy, !switchReady);
      if (selectReq != '0 && prevReq == '0) begin
        checkOutput("breakBeforeMake", ackLowSeen, 1'b1);
        ackLowSeen = 1'b0;
      end
      if (selectReq == '0 && selectAck == '0) ackLowSeen = 1'b1;
      prevReq = selectReq;
    end
  end

  initial begin
    int target;
    int cycles;
    rstN = 1'b0;
    repeat (3) stepClk();
    checkOutput("resetSelectReq", selectReq, '0);
    checkOutput("resetBusy", busy, 1'b1);
    checkOutput("resetReady", switchReady, 1'b0);
    checkOutput("resetDone", switchDone, 1'b0);
    checkOutput("resetCurSel", curSel, RESET_SEL);
    checkOutput("resetErrInvalid", errInvalid, 1'b0);
    checkOutput("resetErrTimeout", errTimeout, 1'b0);

    rstN = 1'b1;
    stepClk();
    checkOutput("bootRaise", selectReq, sourceBit(RESET_SEL));
    waitIdle("bootIdle");
    checkOutput("bootCurSel", curSel, RESET_SEL);
    checkOutput("bootBusy", busy, 1'b0);
    checkOutput("bootReq", selectReq, sourceBit(RESET_SEL));
    curModel = RESET_SEL;
    errInvModel = 0;

    $display("[TB] directed switches");
    applyStimulus(2, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(1, 1'b1);
    applyStimulus(3, 1'b1);

    // clear in IDLE only touches the sticky flags
    errClr = 1'b1;
    stepClk();
    errClr = 1'b0;
    errInvModel = 0;
    checkOutput("clrErrInvalid", errInvalid, 1'b0);
    checkOutput("clrStaysIdle", switchReady, 1'b1);
    checkOutput("clrCurSel", curSel, curModel);

    $display("[TB] random switches");
    for (int n = 0; n < 24; n++) begin
      applyStimulus($urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] timeout on stuck ack");
    target = (curModel == 1) ? 2 : 1;
    stuckHigh[curModel] = 1'b1;
    switchReq = 1'b1;
    switchSel = SEL_W'(target);
    stepClk();
    switchReq = 1'b0;
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      stepClk();
      checkOutput("noDoneWhileStuck", switchDone, 1'b0);
    end
    checkOutput("noEarlyTimeout", errTimeout, 1'b0);
    checkOutput("stillDropping", selectReq, '0);
    stepClk();
    checkOutput("timeoutFlag", errTimeout, 1'b1);
    checkOutput("faultReq", selectReq, '0);
    checkOutput("faultBusy", busy, 1'b1);
    checkOutput("faultNoDone", switchDone, 1'b0);
    checkOutput("faultCurSel", curSel, curModel);
    repeat (3) stepClk();
    checkOutput("faultHolds", switchReady, 1'b0);
    checkOutput("faultErrSticky", errTimeout, 1'b1);
    stuckHigh = '0;
    errClr = 1'b1;
    stepClk();
    errClr = 1'b0;
    checkOutput("faultClrTimeout", errTimeout, 1'b0);
    checkOutput("faultClrInvalid", errInvalid, 1'b0);
    errInvModel = 0;
    waitIdle("rebootIdle");
    curModel = RESET_SEL;
    checkOutput("rebootCurSel", curSel, RESET_SEL);
    checkOutput("rebootReq", selectReq, sourceBit(RESET_SEL));

    applyStimulus(2, 1'b0);

    $display("[TB] reset during raise");
    switchReq = 1'b1;
    switchSel = SEL_W'(1);
    stepClk();
    switchReq = 1'b0;
    cycles = 0;
    while (selectReq == '0 && cycles < 40) begin
      stepClk();
      cycles++;
    end
    checkOutput("reachedRaise", selectReq, sourceBit(1));
    rstN = 1'b0;
    #1;
    checkOutput("midResetReq", selectReq, '0);
    checkOutput("midResetBusy", busy, 1'b1);
    checkOutput("midResetReady", switchReady, 1'b0);
    checkOutput("midResetCurSel", curSel, RESET_SEL);
    repeat (2) stepClk();
    rstN = 1'b1;
    stepClk();
    checkOutput("rebootAfterReset", selectReq, sourceBit(RESET_SEL));
    waitIdle("idleAfterReset");
    curModel = RESET_SEL;
    errInvModel = 0;
    checkOutput("curSelAfterReset", curSel, RESET_SEL);

    applyStimulus(1, 1'b0);
    applyStimulus(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
